// File: rtl/fir_ctrl_multi_pkg.sv
`default_nettype none
// ============================================================================
// Module : fir_ctrl_multi_pkg
// Brief  : State encoding shared by the multi-channel FIR controller files.
// Rev    : 1.0  initial release
// ============================================================================
package fir_ctrl_multi_pkg;

    localparam int unsigned c_state_w = 3;

    typedef logic [c_state_w-1:0] state_t;

    localparam state_t c_st_init  = 3'd0;
    localparam state_t c_st_idle  = 3'd1;
    localparam state_t c_st_mac   = 3'd2;
    localparam state_t c_st_drain = 3'd3;
    localparam state_t c_st_out   = 3'd4;

endpackage
`default_nettype wire

// File: rtl/fir_ctrl_multi_hist_ram.sv
`default_nettype none
// ============================================================================
// Module : fir_ctrl_multi_hist_ram
// Brief  : Simple dual-port history RAM, write-first, 1-cycle registered read.
// Rev    : 1.0  initial release
// ============================================================================
module fir_ctrl_multi_hist_ram #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 101,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_we && (i_waddr == i_raddr)) begin
            o_rdata <= i_wdata;
        end else begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/fir_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module : fir_ctrl_multi
// Brief  : Multi-channel FIR controller: frame capture into a history ring,
//          parallel per-channel MAC against an external ROM, round/saturate.
// Rev    : 1.0  initial release
// ============================================================================
module fir_ctrl_multi
    import fir_ctrl_multi_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int NCHAN     = 2,
    parameter int NTAPS     = 101,
    parameter int ADDR_W    = 7,
    parameter int ACC_W     = 40,
    parameter int FRAC_BITS = 15
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sample_end,
    input  logic [NCHAN*DATA_W-1:0] audio_input,
    input  logic                    bypass,
    output logic [ADDR_W-1:0]       kernel_addr,
    input  logic [COEF_W-1:0]       kernel_data,
    output logic [NCHAN*DATA_W-1:0] audio_output,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    overrun
);

    localparam int          c_prod_w = DATA_W + COEF_W;
    localparam logic [ADDR_W-1:0] c_last = ADDR_W'(NTAPS - 1);
    localparam logic signed [ACC_W-1:0] c_round   = ACC_W'(1) << (FRAC_BITS - 1);
    localparam logic signed [ACC_W-1:0] c_sat_max = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_sat_min = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    logic                     r_sync1, r_sync2, r_sync3;
    logic                     w_edge;
    state_t                   r_state, w_next_state;
    logic [ADDR_W-1:0]        r_cnt, r_wr_ptr, r_rd_ptr;
    logic                     r_dv;
    logic                     w_busy, w_issue, w_capture, w_init_wr;
    logic                     w_we;
    logic [ADDR_W-1:0]        w_waddr;
    logic [NCHAN*DATA_W-1:0]  w_wdata, w_rdata, w_result;
    logic signed [COEF_W-1:0] w_coef;
    logic [DATA_W-1:0]        w_res [NCHAN];
    logic [NCHAN*DATA_W-1:0]  r_out;
    logic                     r_out_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= sample_end;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_edge = r_sync2 & ~r_sync3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_init;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_init:  if (r_cnt == c_last) w_next_state = c_st_idle;
            c_st_idle:  if (w_edge && !bypass) w_next_state = c_st_mac;
            c_st_mac:   if (r_cnt == c_last) w_next_state = c_st_drain;
            c_st_drain: w_next_state = c_st_out;
            c_st_out:   w_next_state = c_st_idle;
            default:    w_next_state = c_st_init;
        endcase
    end

    always_comb begin
        w_busy    = 1'b1;
        w_issue   = 1'b0;
        w_capture = 1'b0;
        w_init_wr = 1'b0;
        case (r_state)
            c_st_init: w_init_wr = 1'b1;
            c_st_idle: begin
                w_busy    = 1'b0;
                w_capture = w_edge;
            end
            c_st_mac:  w_issue = 1'b1;
            default:   ;
        endcase
    end

    // r_cnt serves as the INIT clear address and the MAC tap index; both end wrapped to 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (w_init_wr || w_issue) begin
            r_cnt <= (r_cnt == c_last) ? '0 : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (w_capture) begin
            r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + 1'b1;
            r_rd_ptr <= r_wr_ptr;
        end else if (w_issue) begin
            r_rd_ptr <= (r_rd_ptr == '0) ? c_last : r_rd_ptr - 1'b1;
        end
    end

    assign w_we    = w_init_wr | w_capture;
    assign w_waddr = w_init_wr ? r_cnt : r_wr_ptr;
    assign w_wdata = w_init_wr ? '0 : audio_input;

    fir_ctrl_multi_hist_ram #(
        .WIDTH  (NCHAN*DATA_W),
        .DEPTH  (NTAPS),
        .ADDR_W (ADDR_W)
    ) u_hist_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    // RAM and ROM data for a tap issued in cycle t are both valid in cycle t+1.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dv <= 1'b0;
        end else begin
            r_dv <= w_issue;
        end
    end

    assign w_coef = kernel_data;

    generate
        for (genvar c = 0; c < NCHAN; c++) begin : g_chan
            logic signed [DATA_W-1:0]   w_smp;
            logic signed [c_prod_w-1:0] w_prod;
            logic signed [ACC_W-1:0]    r_acc, w_rnd, w_shr;

            assign w_smp  = w_rdata[c*DATA_W +: DATA_W];
            assign w_prod = w_smp * w_coef;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_acc <= '0;
                end else if (w_capture) begin
                    r_acc <= '0;
                end else if (r_dv) begin
                    r_acc <= r_acc + {{(ACC_W-c_prod_w){w_prod[c_prod_w-1]}}, w_prod};
                end
            end

            assign w_rnd    = r_acc + c_round;
            assign w_shr    = w_rnd >>> FRAC_BITS;
            assign w_res[c] = (w_shr > c_sat_max) ? c_sat_max[DATA_W-1:0] :
                              (w_shr < c_sat_min) ? c_sat_min[DATA_W-1:0] :
                                                    w_shr[DATA_W-1:0];
        end
    endgenerate

    always_comb begin
        w_result = '0;
        for (int c = 0; c < NCHAN; c++) begin
            w_result[c*DATA_W +: DATA_W] = w_res[c];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_capture && bypass) begin
                r_out       <= audio_input;
                r_out_valid <= 1'b1;
            end else if (r_state == c_st_out) begin
                r_out       <= w_result;
                r_out_valid <= 1'b1;
            end
        end
    end

    assign kernel_addr  = w_issue ? r_cnt : '0;
    assign busy         = w_busy;
    assign overrun      = w_edge & w_busy;
    assign audio_output = r_out;
    assign out_valid    = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_fir_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module : tb_fir_ctrl_multi
// Brief  : Self-checking bench for fir_ctrl_multi against a behavioural FIR model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fir_ctrl_multi;

    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int NCHAN     = 2;
    localparam int NTAPS     = 101;
    localparam int ADDR_W    = 7;
    localparam int ACC_W     = 40;
    localparam int FRAC_BITS = 15;
    localparam int FW        = NCHAN * DATA_W;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              sample_end;
    logic [FW-1:0]     audio_input;
    logic              bypass;
    logic [ADDR_W-1:0] kernel_addr;
    logic [COEF_W-1:0] kernel_data;
    logic [FW-1:0]     audio_output;
    logic              out_valid;
    logic              busy;
    logic              overrun;

    logic [COEF_W-1:0] rom [NTAPS];
    logic [FW-1:0]     hist [$];
    int                n_cmp = 0;
    int                n_bad = 0;

    always #5 clk = ~clk;

    // Registered coefficient ROM, one cycle of latency.
    always @(posedge clk) kernel_data <= rom[int'(kernel_addr) % NTAPS];

    fir_ctrl_multi #(
        .DATA_W    (DATA_W),
        .COEF_W    (COEF_W),
        .NCHAN     (NCHAN),
        .NTAPS     (NTAPS),
        .ADDR_W    (ADDR_W),
        .ACC_W     (ACC_W),
        .FRAC_BITS (FRAC_BITS)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_end   (sample_end),
        .audio_input  (audio_input),
        .bypass       (bypass),
        .kernel_addr  (kernel_addr),
        .kernel_data  (kernel_data),
        .audio_output (audio_output),
        .out_valid    (out_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // y_c = sat(round(sum_k coef[k] * x_c[n-k])), history newest first, zero beyond.
    function automatic logic [FW-1:0] model_out();
        logic [FW-1:0] r;
        longint        s;
        longint        lim_hi, lim_lo;
        logic signed [DATA_W-1:0] x;
        logic signed [COEF_W-1:0] h;
        lim_hi = (longint'(1) << (DATA_W - 1)) - 1;
        lim_lo = -(longint'(1) << (DATA_W - 1));
        r = '0;
        for (int c = 0; c < NCHAN; c++) begin
            s = 0;
            for (int k = 0; k < hist.size(); k++) begin
                x = hist[k][c*DATA_W +: DATA_W];
                h = rom[k];
                s += longint'(x) * longint'(h);
            end
            s = (s + (longint'(1) << (FRAC_BITS - 1))) >>> FRAC_BITS;
            if (s > lim_hi) s = lim_hi;
            else if (s < lim_lo) s = lim_lo;
            r[c*DATA_W +: DATA_W] = s[DATA_W-1:0];
        end
        return r;
    endfunction

    task automatic push_hist(input logic [FW-1:0] f);
        hist.push_front(f);
        if (hist.size() > NTAPS) hist.delete(hist.size() - 1);
    endtask

    task automatic wait_init();
        for (int n = 1; n <= NTAPS; n++) begin
            @(posedge clk); #1;
            if (n == NTAPS - 1) check("init_busy_high", 64'(busy), 64'd1);
            if (n == NTAPS)     check("init_busy_low", 64'(busy), 64'd0);
        end
    endtask

    // One capture; checks latency, data, single pulse, busy profile, kernel_addr sequence.
    task automatic run_frame(input logic [FW-1:0] f, input logic byp);
        logic [FW-1:0] exp_out, got;
        int  exp_lat, lat, n_valid, limit, ea;
        bit  eb, busy_ok, addr_ok, ovr_seen;
        push_hist(f);
        exp_out = byp ? f : model_out();
        exp_lat = byp ? 3 : NTAPS + 5;
        limit   = byp ? 8 : NTAPS + 8;
        lat = 0; n_valid = 0; busy_ok = 1; addr_ok = 1; ovr_seen = 0; got = '0;
        @(posedge clk); #1;
        audio_input = f;
        bypass      = byp;
        sample_end  = 1'b1;
        for (int n = 1; n <= limit; n++) begin
            @(posedge clk); #1;
            if (n == 4) sample_end = 1'b0;
            eb = !byp && (n >= 3) && (n <= NTAPS + 4);
            ea = (!byp && (n >= 3) && (n <= NTAPS + 2)) ? n - 3 : 0;
            if (busy !== eb) busy_ok = 0;
            if (kernel_addr !== ADDR_W'(ea)) addr_ok = 0;
            if (overrun !== 1'b0) ovr_seen = 1;
            if (out_valid === 1'b1) begin
                n_valid++;
                if (lat == 0) begin
                    lat = n;
                    got = audio_output;
                end
            end
        end
        check(byp ? "byp_latency" : "mac_latency", 64'(lat), 64'(exp_lat));
        check(byp ? "byp_data" : "mac_data", 64'(got), 64'(exp_out));
        check("valid_pulses", 64'(n_valid), 64'd1);
        check("busy_profile", 64'(busy_ok), 64'd1);
        check("kaddr_sequence", 64'(addr_ok), 64'd1);
        check("no_overrun", 64'(ovr_seen), 64'd0);
        check("output_held", 64'(audio_output), 64'(exp_out));
    endtask

    task automatic reset_checks(input string pfx);
        check({pfx, "_audio_output"}, 64'(audio_output), 64'd0);
        check({pfx, "_out_valid"}, 64'(out_valid), 64'd0);
        check({pfx, "_overrun"}, 64'(overrun), 64'd0);
        check({pfx, "_kernel_addr"}, 64'(kernel_addr), 64'd0);
        check({pfx, "_busy"}, 64'(busy), 64'd1);
    endtask

    initial begin : main
        logic [FW-1:0] f, fb;
        int ovr_cnt, ovr_n, n_valid;
        logic [FW-1:0] got, exp_out;

        for (int k = 0; k < NTAPS; k++) rom[k] = '0;
        reset_n     = 1'b0;
        sample_end  = 1'b0;
        bypass      = 1'b0;
        audio_input = '0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");
        reset_n = 1'b1;
        wait_init();

        // Identity kernel.
        rom[0] = 16'h7FFF;
        run_frame({16'hC000, 16'h1234}, 1'b0);

        // Bypass, then the bypassed frame must appear at tap 1.
        run_frame({16'hAAAA, 16'h5555}, 1'b1);
        rom[0] = '0;
        rom[1] = 16'h7FFF;
        run_frame('0, 1'b0);

        // Impulse through a ramp kernel.
        for (int k = 0; k < NTAPS; k++) rom[k] = COEF_W'(k * 256);
        run_frame({2{16'h7FFF}}, 1'b0);
        for (int i = 0; i < 5; i++) run_frame('0, 1'b0);

        // Saturation both directions at once; also wraps the ring.
        for (int k = 0; k < NTAPS; k++) rom[k] = 16'h7FFF;
        for (int i = 0; i < NTAPS + 3; i++) run_frame({16'h8000, 16'h7FFF}, 1'b0);

        // Randomised kernel, samples and bypass.
        for (int k = 0; k < NTAPS; k++) rom[k] = COEF_W'($urandom_range(0, 2047)) - 16'd1024;
        for (int i = 0; i < 30; i++) run_frame(FW'($urandom), ($urandom_range(0, 4) == 0));

        // Overrun: second rise 10 cycles after the first is dropped.
        f  = FW'($urandom);
        fb = FW'($urandom);
        push_hist(f);
        exp_out = model_out();
        ovr_cnt = 0; ovr_n = 0; n_valid = 0; got = '0;
        @(posedge clk); #1;
        audio_input = f; bypass = 1'b0; sample_end = 1'b1;
        for (int n = 1; n <= NTAPS + 8; n++) begin
            @(posedge clk); #1;
            if (n == 4)  sample_end = 1'b0;
            if (n == 10) begin audio_input = fb; sample_end = 1'b1; end
            if (n == 14) sample_end = 1'b0;
            if (overrun === 1'b1) begin ovr_cnt++; ovr_n = n; end
            if (out_valid === 1'b1) begin n_valid++; got = audio_output; end
        end
        check("overrun_count", 64'(ovr_cnt), 64'd1);
        check("overrun_cycle", 64'(ovr_n), 64'd12);
        check("overrun_valids", 64'(n_valid), 64'd1);
        check("overrun_data", 64'(got), 64'(exp_out));
        for (int i = 0; i < 3; i++) run_frame(FW'($urandom), 1'b0);

        // Reset in the middle of a MAC, then history must read back as zero.
        @(posedge clk); #1;
        audio_input = FW'($urandom); bypass = 1'b0; sample_end = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("mid_mac_kaddr", 64'(kernel_addr), 64'd1);
        reset_n = 1'b0; sample_end = 1'b0;
        #1;
        reset_checks("midreset");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        hist.delete();
        wait_init();
        for (int i = 0; i < 3; i++) run_frame(FW'($urandom), 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
